mdr_load_unit: RTL and testbench

Load-access sequencer between the multicycle control unit and data memory. On a load request it checks address alignment, drives the memory read, waits a fixed memory latency, and captures the returned word into the memory data register (MDR). The captured word and its size command go directly to `load_size`, which extracts the byte, halfword or word for the register write-back mux.

---
 rtl/mdr_load_unit.sv | 193 +++++++++++++++++++
 tb/tb_mdr_load_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_load_unit.sv
// ============================================================================
// mdr_load_unit
// ----------------------------------------------------------------------------
// Load-access sequencer between the multicycle control unit and data memory.
// A load request is checked for alignment. If it is legal, the unit drives a
// memory read, waits MEM_LATENCY edges, and then captures the returned word
// into the memory data register (MDR). The captured word and its access size
// go straight to load_size, which extracts the byte, halfword or word.
//
// Parameters
//   MEM_LATENCY  edges between the first cycle mem_rd is high and the cycle
//                mem_rdata is valid (legal range 1..15)
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-high reset
//   ld_start     in   1   load request, sampled at each rising edge
//   ld_addr      in  32   byte address, sampled with ld_start
//   ld_size      in   2   00 byte, 01 halfword, 10 word, 11 illegal
//   mem_addr     out 32   address to data memory (held after completion)
//   mem_rd       out  1   memory read enable
//   mem_rdata    in  32   word at mem_addr
//   mdr          out 32   captured memory word (unshifted)
//   size_cmd     out  2   size of the access that produced mdr
//   busy         out  1   load in flight; new requests are ignored
//   done         out  1   one-cycle pulse, mdr/size_cmd final
//   misaligned   out  1   one-cycle pulse, request rejected
//
// Every output comes straight from a flop. There is no combinational path
// from any input to any output.
// ============================================================================
module mdr_load_unit #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_start,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_size,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mdr,
    output logic [1:0]  size_cmd,
    output logic        busy,
    output logic        done,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    state_t      r_state,    w_state_nxt;
    logic [3:0]  r_cnt,      w_cnt_nxt;
    logic [1:0]  r_size,     w_size_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic        r_mem_rd,   w_mem_rd_nxt;
    logic [31:0] r_mdr,      w_mdr_nxt;
    logic [1:0]  r_size_cmd, w_size_cmd_nxt;
    logic        r_busy,     w_busy_nxt;
    logic        r_done,     w_done_nxt;
    logic        r_mis,      w_mis_nxt;

    logic        w_legal;

    // Alignment / size legality of the request currently on the inputs.
    always_comb begin
        w_legal = 1'b0;
        unique case (ld_size)
            2'b00:   w_legal = 1'b1;
            2'b01:   w_legal = ~ld_addr[0];
            2'b10:   w_legal = (ld_addr[1:0] == 2'b00);
            default: w_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_size_nxt     = r_size;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_rd_nxt   = r_mem_rd;
        w_mdr_nxt      = r_mdr;
        w_size_cmd_nxt = r_size_cmd;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_mis_nxt      = 1'b0;

        unique case (r_state)
            // DONE samples ld_start exactly like IDLE, which allows
            // back-to-back loads without a dead cycle.
            S_IDLE, S_DONE: begin
                w_state_nxt  = S_IDLE;
                w_mem_rd_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
                if (ld_start) begin
                    if (w_legal) begin
                        w_state_nxt    = S_WAIT;
                        w_mem_addr_nxt = ld_addr;
                        w_size_nxt     = ld_size;
                        w_cnt_nxt      = LAT;
                        w_mem_rd_nxt   = 1'b1;
                        w_busy_nxt     = 1'b1;
                    end else begin
                        // Rejected: only the pulse changes, the
                        // captured data and the address are left alone.
                        w_mis_nxt = 1'b1;
                    end
                end
            end

            // The counter is loaded with L and reaches 0 after L edges, so
            // the capture happens at edge L+1 after the accepting edge.
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt    = S_DONE;
                    w_mdr_nxt      = mem_rdata;
                    w_size_cmd_nxt = r_size;
                    w_mem_rd_nxt   = 1'b0;
                    w_busy_nxt     = 1'b0;
                    w_done_nxt     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            default: begin
                w_state_nxt  = S_IDLE;
                w_mem_rd_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= 4'd0;
            r_size     <= 2'b00;
            r_mem_addr <= 32'd0;
            r_mem_rd   <= 1'b0;
            r_mdr      <= 32'd0;
            r_size_cmd <= 2'b00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mis      <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_size     <= w_size_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mdr      <= w_mdr_nxt;
            r_size_cmd <= w_size_cmd_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_mis      <= w_mis_nxt;
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_rd     = r_mem_rd;
    assign mdr        = r_mdr;
    assign size_cmd   = r_size_cmd;
    assign busy       = r_busy;
    assign done       = r_done;
    assign misaligned = r_mis;

endmodule

// File: tb/tb_mdr_load_unit.sv
// ============================================================================
// tb_mdr_load_unit
// ----------------------------------------------------------------------------
// Self-checking bench for mdr_load_unit. Two instances share the inputs:
// u1 has MEM_LATENCY=1 and is driven by a vector table. u3 has MEM_LATENCY=3
// and is exercised by hand-written multi-cycle sequences.
//
// The memory model returns valid data only in the cycle where mem_rd has
// been high for exactly L edges. Any other cycle returns a poison word, so a
// capture taken one edge early or one edge late shows up in mdr.
// ============================================================================
module tb_mdr_load_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_start;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;

    logic [31:0] mem_addr1, mem_rdata1, mdr1;
    logic        mem_rd1, busy1, done1, mis1;
    logic [1:0]  sc1;
    logic [31:0] mem_addr3, mem_rdata3, mdr3;
    logic        mem_rd3, busy3, done3, mis3;
    logic [1:0]  sc3;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mdr_load_unit #(.MEM_LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .ld_start(ld_start), .ld_addr(ld_addr),
        .ld_size(ld_size), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
        .mem_rdata(mem_rdata1), .mdr(mdr1), .size_cmd(sc1), .busy(busy1),
        .done(done1), .misaligned(mis1)
    );

    mdr_load_unit #(.MEM_LATENCY(3)) u3 (
        .clk(clk), .reset(reset), .ld_start(ld_start), .ld_addr(ld_addr),
        .ld_size(ld_size), .mem_addr(mem_addr3), .mem_rd(mem_rd3),
        .mem_rdata(mem_rdata3), .mdr(mdr3), .size_cmd(sc3), .busy(busy3),
        .done(done3), .misaligned(mis3)
    );

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0010: mem_word = 32'hDEAD_BEEF;
            32'h0000_0007: mem_word = 32'h1234_5678;
            32'h0000_0020: mem_word = 32'hCAFE_F00D;
            default:       mem_word = a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    int rd_cnt1 = 0;
    int rd_cnt3 = 0;
    always @(posedge clk) begin
        rd_cnt1 <= mem_rd1 ? rd_cnt1 + 1 : 0;
        rd_cnt3 <= mem_rd3 ? rd_cnt3 + 1 : 0;
    end
    assign mem_rdata1 = (rd_cnt1 == 1) ? mem_word(mem_addr1) : (32'hBAD0_0000 | 32'(rd_cnt1));
    assign mem_rdata3 = (rd_cnt3 == 3) ? mem_word(mem_addr3) : (32'hBAD0_0000 | 32'(rd_cnt3));

    // ---------------- checking helpers ----------------
    // Output bundle: {mem_rd, busy, done, misaligned, size_cmd, mem_addr, mdr}
    function automatic logic [69:0] bundle(input logic rd, input logic bz,
                                           input logic dn, input logic ms,
                                           input logic [1:0] sc,
                                           input logic [31:0] ma,
                                           input logic [31:0] md);
        bundle = {rd, bz, dn, ms, sc, ma, md};
    endfunction

    task automatic check(input string name, input logic [69:0] act,
                         input logic [69:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got rd/bz/dn/ms=%b sc=%b addr=%h mdr=%h, want rd/bz/dn/ms=%b sc=%b addr=%h mdr=%h",
                     name, act[69:66], act[65:64], act[63:32], act[31:0],
                     exp[69:66], exp[65:64], exp[63:32], exp[31:0]);
        end
    endtask

    task automatic chk3(input string name, input logic rd, input logic bz,
                        input logic dn, input logic ms, input logic [1:0] sc,
                        input logic [31:0] ma, input logic [31:0] md);
        check(name, bundle(mem_rd3, busy3, done3, mis3, sc3, mem_addr3, mdr3),
              bundle(rd, bz, dn, ms, sc, ma, md));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rs, input logic st,
                         input logic [31:0] a, input logic [1:0] s);
        reset    = rs;
        ld_start = st;
        ld_addr  = a;
        ld_size  = s;
    endtask

    // ---------------- vector table (L = 1) ----------------
    typedef struct {
        logic        rst;
        logic        start;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        rd, bz, dn, ms;
        logic [1:0]  sc;
        logic [31:0] maddr;
        logic [31:0] mdr;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          rst st addr          sz     rd bz dn ms sc     maddr         mdr
        // reset held two cycles while a request is presented
        vecs[0]  = '{1'b1, 1'b1, 32'h0000_0010, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_0044, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0};
        // word load at 0x10: accept, wait, capture, idle
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0010, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h10, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0000_0000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h10, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h10, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h10, 32'hDEAD_BEEF};
        // rejects: odd halfword, size 11, word at 0x12
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0013, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0012, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h10, 32'hDEAD_BEEF};
        // legal halfword at 0x12
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0012, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h12, 32'hDEAD_BEEF};
        vecs[11] = '{1'b0, 1'b0, 32'h0000_0000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h12, 32'hDEAD_BEEF};
        vecs[12] = '{1'b0, 1'b0, 32'h0000_0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 32'h12, 32'hA5A5_A5B7};
        vecs[13] = '{1'b0, 1'b0, 32'h0000_0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'h12, 32'hA5A5_A5B7};

        drive(1'b1, 1'b0, 32'h0, 2'd0);
        #1;
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].addr, vecs[i].size);
            step();
            check($sformatf("vec%0d", i),
                  bundle(mem_rd1, busy1, done1, mis1, sc1, mem_addr1, mdr1),
                  bundle(vecs[i].rd, vecs[i].bz, vecs[i].dn, vecs[i].ms,
                         vecs[i].sc, vecs[i].maddr, vecs[i].mdr));
        end

        // ---------------- L = 3, byte load at 0x7 ----------------
        drive(1'b1, 1'b1, 32'($urandom), 2'($urandom));
        step();
        drive(1'b1, 1'b1, 32'($urandom), 2'($urandom));
        step();
        chk3("t4_reset", 0, 0, 0, 0, 2'd0, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 32'h7, 2'd0);
        step();
        chk3("t4_e0", 1, 1, 0, 0, 2'd0, 32'h7, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 2'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk3($sformatf("t4_e%0d", i), 1, 1, 0, 0, 2'd0, 32'h7, 32'h0);
        end
        step();
        chk3("t4_e4", 0, 0, 1, 0, 2'd0, 32'h7, 32'h1234_5678);
        step();
        chk3("t4_e5", 0, 0, 0, 0, 2'd0, 32'h7, 32'h1234_5678);

        // ---------------- L = 3, ld_start held high ----------------
        drive(1'b0, 1'b1, 32'h100, 2'd2);
        step();
        chk3("t5_e0", 1, 1, 0, 0, 2'd0, 32'h100, 32'h1234_5678);
        drive(1'b0, 1'b1, 32'h200, 2'd2);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk3($sformatf("t5_e%0d", i), 1, 1, 0, 0, 2'd0, 32'h100, 32'h1234_5678);
        end
        step();
        chk3("t5_e4", 0, 0, 1, 0, 2'd2, 32'h100, 32'hA5A5_A4A5);
        step();
        chk3("t5_e5", 1, 1, 0, 0, 2'd2, 32'h200, 32'hA5A5_A4A5);
        for (int i = 6; i <= 8; i++) begin
            step();
            chk3($sformatf("t5_e%0d", i), 1, 1, 0, 0, 2'd2, 32'h200, 32'hA5A5_A4A5);
        end
        step();
        chk3("t5_e9", 0, 0, 1, 0, 2'd2, 32'h200, 32'hA5A5_A7A5);
        drive(1'b0, 1'b0, 32'h0, 2'd0);
        step();
        chk3("t5_e10", 0, 0, 0, 0, 2'd2, 32'h200, 32'hA5A5_A7A5);

        // ---------------- L = 3, reset mid-load ----------------
        drive(1'b0, 1'b1, 32'h20, 2'd2);
        step();
        chk3("t6_e0", 1, 1, 0, 0, 2'd2, 32'h20, 32'hA5A5_A7A5);
        step();
        chk3("t6_e1", 1, 1, 0, 0, 2'd2, 32'h20, 32'hA5A5_A7A5);
        drive(1'b1, 1'b1, 32'h20, 2'd2);
        step();
        chk3("t6_rst", 0, 0, 0, 0, 2'd0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 2'd0);
        for (int i = 3; i <= 5; i++) begin
            step();
            chk3($sformatf("t6_quiet%0d", i), 0, 0, 0, 0, 2'd0, 32'h0, 32'h0);
        end
        drive(1'b0, 1'b1, 32'h20, 2'd2);
        step();
        chk3("t6b_e0", 1, 1, 0, 0, 2'd0, 32'h20, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 2'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk3($sformatf("t6b_e%0d", i), 1, 1, 0, 0, 2'd0, 32'h20, 32'h0);
        end
        step();
        chk3("t6b_e4", 0, 0, 1, 0, 2'd2, 32'h20, 32'hCAFE_F00D);
        step();
        chk3("t6b_e5", 0, 0, 0, 0, 2'd2, 32'h20, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
